add_sequencer: RTL and testbench

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_seq_pkg.sv | 19 +
 rtl/add_sequencer_eightbit.sv | 26 ++
 rtl/add_sequencer.sv | 151 +++++++++++++++
 tb/tb_add_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared definitions for the chunked add sequencer: FSM encoding, default
// geometry and a helper sizing the chunk counter.
package add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_N      = 8;
    localparam int DEF_CHUNKS = 4;

    // Width of a counter that indexes 0..chunks-1, never narrower than 1 bit.
    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/add_sequencer_eightbit.sv
// Team n-bit ripple-carry adder: the carry walks from bit 0 to bit n-1
// through one full-adder cell per bit.
module eightbit #(
    parameter int n = 8
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    input  logic         cin_i,
    output logic [n-1:0] sum_o,
    output logic         cout_o
);

    logic carry;

    // Ripple the carry bit by bit; carry is a running value, not a vector.
    always_comb begin
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < n; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/add_sequencer.sv
// Two-requester W-bit adder that time-shares one N-bit ripple adder,
// processing one chunk per cycle from least significant upward.
//
// Handshake: a requester raises reqK_valid with operands and holds them until
// it sees reqK_ready high; that cycle is the accept and the operands are
// latched, later changes are ignored. reqK_ready is a combinational function
// of valid, state and rst, high only in IDLE for the granted requester. The
// result side holds res_valid with stable res_* until the cycle res_ready is
// high; the sequencer returns to IDLE on the following cycle, so a new accept
// can never coincide with a result accept.
module add_sequencer
    import add_seq_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int CHUNKS = DEF_CHUNKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [N*CHUNKS-1:0]   req0_a,
    input  logic [N*CHUNKS-1:0]   req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [N*CHUNKS-1:0]   req1_a,
    input  logic [N*CHUNKS-1:0]   req1_b,
    input  logic                  req1_cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [N*CHUNKS-1:0]   res_sum,
    output logic                  res_cout,
    output logic                  res_id,
    output logic [1:0]            dbg_state
);

    localparam int W  = N * CHUNKS;
    localparam int CW = cnt_width(CHUNKS);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          carry_q;
    logic          id_q;
    logic          last_id_q;   // requester granted most recently; 1 after reset so req0 wins first
    logic [CW-1:0] cnt_q;

    logic          grant_id;
    logic          accept;
    logic          last_chunk;
    logic [N-1:0]  a_chunk, b_chunk, add_sum;
    logic          add_cout;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_id_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept     = (state_q == ST_IDLE) && (req0_valid || req1_valid) && !rst;
    assign last_chunk = (cnt_q == LAST_CHUNK);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept -> ADD for CHUNKS cycles -> DONE until the result is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)     state_d = ST_ADD;
            ST_ADD:  if (last_chunk) state_d = ST_DONE;
            ST_DONE: if (res_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state and the current grant.
    always_comb begin
        req0_ready = accept && !grant_id;
        req1_ready = accept &&  grant_id;
        res_valid  = (state_q == ST_DONE);
    end

    // Select the operand chunk addressed by the chunk counter.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (cnt_q == CW'(k)) begin
                a_chunk = a_q[k*N +: N];
                b_chunk = b_q[k*N +: N];
            end
        end
    end

    eightbit #(
        .n (N)
    ) u_adder (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Datapath: latch operands at accept, then fold one chunk per ADD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            cnt_q     <= '0;
        end else if (accept) begin
            a_q       <= grant_id ? req1_a   : req0_a;
            b_q       <= grant_id ? req1_b   : req0_b;
            carry_q   <= grant_id ? req1_cin : req0_cin;
            id_q      <= grant_id;
            last_id_q <= grant_id;
            cnt_q     <= '0;
        end else if (state_q == ST_ADD) begin
            for (int k = 0; k < CHUNKS; k++) begin
                if (cnt_q == CW'(k)) begin
                    sum_q[k*N +: N] <= add_sum;
                end
            end
            carry_q <= add_cout;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // After the last chunk the carry register holds the final carry-out and
    // is left untouched in DONE, so it drives res_cout directly.
    assign res_sum   = sum_q;
    assign res_cout  = carry_q;
    assign res_id    = id_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_add_sequencer.sv
`timescale 1ns/1ps
module tb_add_sequencer;
    import add_seq_pkg::*;

    localparam int N          = 8;
    localparam int CHUNKS     = 4;
    localparam int W          = N * CHUNKS;
    localparam int N_RAND_OPS = 10000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (N=8, CHUNKS=4) ----------------
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         res_ready = 1'b1;
    logic         req0_ready, req1_ready, res_valid, res_cout, res_id;
    logic [W-1:0] res_sum;
    logic [1:0]   dbg_state;

    add_sequencer #(.N(N), .CHUNKS(CHUNKS)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
        .dbg_state(dbg_state)
    );

    // ---------------- single-chunk DUT (N=8, CHUNKS=1) ----------------
    logic       u1_req0_valid = 1'b0, u1_req1_valid = 1'b0;
    logic       u1_req0_cin = 1'b0, u1_req1_cin = 1'b0;
    logic [7:0] u1_req0_a = '0, u1_req0_b = '0, u1_req1_a = '0, u1_req1_b = '0;
    logic       u1_res_ready = 1'b1;
    logic       u1_req0_ready, u1_req1_ready, u1_res_valid, u1_res_cout, u1_res_id;
    logic [7:0] u1_res_sum;
    logic [1:0] u1_dbg_state;

    add_sequencer #(.N(8), .CHUNKS(1)) u_dut_c1 (
        .clk(clk), .rst(rst),
        .req0_valid(u1_req0_valid), .req0_ready(u1_req0_ready), .req0_a(u1_req0_a), .req0_b(u1_req0_b), .req0_cin(u1_req0_cin),
        .req1_valid(u1_req1_valid), .req1_ready(u1_req1_ready), .req1_a(u1_req1_a), .req1_b(u1_req1_b), .req1_cin(u1_req1_cin),
        .res_valid(u1_res_valid), .res_ready(u1_res_ready), .res_sum(u1_res_sum), .res_cout(u1_res_cout), .res_id(u1_res_id),
        .dbg_state(u1_dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Result record: {id, cout, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] ref_add(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return {id, full};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom());
        endcase
    endfunction

    logic [W+1:0] exp_q[$];
    int   m_phase = 0;      // 0 idle, 1 computing, 2 result held
    int   m_left  = 0;      // cycles of computation still to run
    logic m_last  = 1'b1;   // requester served last; req0 goes first after reset
    bit   acc0 = 1'b0, acc1 = 1'b0;
    int   n_acc[2];
    int   n_done[2];

    initial begin
        n_acc[0] = 0; n_acc[1] = 0; n_done[0] = 0; n_done[1] = 0;
    end

    // Compare process: every cycle, check handshakes and the held result against the model.
    always @(negedge clk) begin
        logic e_r0, e_r1, g;
        logic [W+1:0] e;
        e_r0 = 1'b0; e_r1 = 1'b0; g = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0;
        if (!rst && m_phase == 0 && (req0_valid || req1_valid)) begin
            g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = !g;
            e_r1 = g;
        end
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("res_valid", res_valid, (m_phase == 2));
        if (m_phase == 2 && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("res_sum",  res_sum,  e[W-1:0]);
            chk("res_cout", res_cout, e[W]);
            chk("res_id",   res_id,   e[W+1]);
        end
        if (res_valid === 1'b1 && res_ready === 1'b1 && !rst) begin
            n_done[res_id === 1'b1 ? 1 : 0]++;
        end
        if (rst) begin
            foreach (exp_q[i]) n_acc[exp_q[i][W+1] ? 1 : 0]--;
            exp_q.delete();
            m_phase = 0;
            m_last  = 1'b1;
        end else begin
            case (m_phase)
                0: if (e_r0 || e_r1) begin
                    exp_q.push_back(g ? ref_add(1'b1, req1_a, req1_b, req1_cin)
                                      : ref_add(1'b0, req0_a, req0_b, req0_cin));
                    n_acc[g ? 1 : 0]++;
                    m_last  = g;
                    m_phase = 1;
                    m_left  = CHUNKS;
                    acc0    = !g;
                    acc1    = g;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (res_ready) begin
                    void'(exp_q.pop_front());
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit k, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int t;
        @(posedge clk); #1;
        if (k) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
        t = 0;
        do begin @(posedge clk); t++; end while (!(k ? acc1 : acc0) && t < 50);
        chk("issue_accepted_in_time", (t < 50), 1'b1);
        #1;
        // Scramble operands after accept; the result must not change.
        if (k) begin req1_valid = 1'b0; req1_a = W'($urandom()); req1_b = W'($urandom()); req1_cin = ~cin; end
        else   begin req0_valid = 1'b0; req0_a = W'($urandom()); req0_b = W'($urandom()); req0_cin = ~cin; end
    endtask

    // Counts cycles after the accept cycle until res_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (res_valid !== 1'b1 && lat < 30);
    endtask

    task automatic u1_op(input bit k, input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [8:0] exp_full);
        int lat;
        @(posedge clk); #1;
        if (k) begin u1_req1_valid = 1'b1; u1_req1_a = a; u1_req1_b = b; u1_req1_cin = cin; end
        else   begin u1_req0_valid = 1'b1; u1_req0_a = a; u1_req0_b = b; u1_req0_cin = cin; end
        @(negedge clk);
        chk("c1_ready", k ? u1_req1_ready : u1_req0_ready, 1'b1);
        @(posedge clk); #1;
        u1_req0_valid = 1'b0; u1_req1_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (u1_res_valid !== 1'b1 && lat < 20);
        chk("c1_latency", lat, 2);
        chk("c1_sum", u1_res_sum, exp_full[7:0]);
        chk("c1_cout", u1_res_cout, exp_full[8]);
        chk("c1_id", u1_res_id, k);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, t, cyc, n_grant, n_start;
        int grant_cyc[4];
        logic grant_id[4];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_res_valid", res_valid, 1'b0);
        chk("reset_res_sum", res_sum, 0);
        chk("reset_res_cout", res_cout, 1'b0);
        chk("reset_res_id", res_id, 1'b0);
        chk("reset_state", dbg_state, ST_IDLE);

        // Pin the reference model with hand-computed sums.
        chk("model_pin_allones_plus_cin", ref_add(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1), {1'b0, 1'b1, 32'h0000_0000});
        chk("model_pin_mixed", ref_add(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0), {1'b1, 1'b0, 32'hACF1_3568});

        // Single-chunk instance.
        u1_op(1'b0, 8'h80, 8'h80, 1'b0, 9'h100);
        u1_op(1'b1, 8'h7F, 8'h01, 1'b0, 9'h080);

        // Carry through every chunk, latency CHUNKS+1.
        res_ready = 1'b1;
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_result(lat);
        chk("carry_chain_latency", lat, CHUNKS + 1);
        chk("carry_chain_sum", res_sum, 32'h0000_0000);
        chk("carry_chain_cout", res_cout, 1'b1);
        chk("carry_chain_id", res_id, 1'b0);

        // Back-pressured result stays stable and blocks new accepts.
        @(posedge clk); #1 res_ready = 1'b0;
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_result(lat);
        chk("mixed_latency", lat, CHUNKS + 1);
        chk("mixed_sum", res_sum, 32'hACF1_3568);
        chk("mixed_cout", res_cout, 1'b0);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 32'h0000_00FF; req1_b = 32'h0000_0001; req1_cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_sum", res_sum, 32'hACF1_3568);
            chk("hold_no_ready", req1_ready, 1'b0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        t = 0;
        do begin @(posedge clk); t++; end while (!acc1 && t < 20);
        chk("pending_req1_accepted", (t < 20), 1'b1);
        #1 req1_valid = 1'b0;
        wait_result(lat);
        chk("req1_after_hold_sum", res_sum, 32'h0000_0101);
        chk("req1_after_hold_id", res_id, 1'b1);

        // Reset during the second ADD cycle aborts the operation.
        issue(1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_ready0_in_rst", req0_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_res_valid", res_valid, 1'b0);
        chk("abort_state_idle", dbg_state, ST_IDLE);
        chk("abort_sum_cleared", res_sum, 0);
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_result(lat);
        chk("post_abort_latency", lat, CHUNKS + 1);
        chk("post_abort_sum", res_sum, 32'h0000_0000);
        chk("post_abort_cout", res_cout, 1'b1);
        chk("post_abort_id", res_id, 1'b1);

        // Both requesters always valid: grants alternate 0,1,0,1 spaced CHUNKS+2.
        @(posedge clk); #1;
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = rand_operand(); req0_b = rand_operand(); req0_cin = 1'b1;
        req1_valid = 1'b1; req1_a = rand_operand(); req1_b = rand_operand(); req1_cin = 1'b0;
        @(negedge clk);
        chk("rst_gates_ready0", req0_ready, 1'b0);
        chk("rst_gates_ready1", req1_ready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        n_grant = 0; cyc = 0;
        while (n_grant < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                grant_cyc[n_grant] = cyc;
                grant_id[n_grant]  = req1_ready;
                n_grant++;
            end
        end
        chk("alternate_grant_count", n_grant, 4);
        chk("alternate_first", grant_id[0], 1'b0);
        chk("alternate_second", grant_id[1], 1'b1);
        chk("alternate_third", grant_id[2], 1'b0);
        chk("alternate_fourth", grant_id[3], 1'b1);
        for (int i = 1; i < 4; i++) chk("alternate_spacing", grant_cyc[i] - grant_cyc[i-1], CHUNKS + 2);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (CHUNKS + 4) @(posedge clk);

        // Randomised traffic with random back-pressure.
        n_start = n_acc[0] + n_acc[1];
        cyc = 0;
        while ((n_acc[0] + n_acc[1] - n_start) < N_RAND_OPS && cyc < 90000) begin
            @(posedge clk); #1;
            cyc++;
            res_ready = ($urandom_range(0, 7) != 0);
            if (acc0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a = rand_operand(); req0_b = rand_operand(); req0_cin = 1'($urandom_range(0, 1));
            end
            if (acc1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = rand_operand(); req1_b = rand_operand(); req1_cin = 1'($urandom_range(0, 1));
            end
        end
        chk("random_ops_completed_in_budget", ((n_acc[0] + n_acc[1] - n_start) >= N_RAND_OPS), 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        repeat (CHUNKS + 6) @(posedge clk);
        chk("req0_accepted_eq_completed", n_done[0], n_acc[0]);
        chk("req1_accepted_eq_completed", n_done[1], n_acc[1]);
        chk("nothing_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
